// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester: SDRAM self-test engine. Writes a selectable pattern
// over [START_ADDR, END_ADDR] through the controller request/busy handshake,
// reads the window back and compares each word against the regenerated pattern.
// Ports:
//   inputClock, reset_n                  clock, async active-low reset
//   start, patternMode                   test launch and pattern select
//   isBusy, inputDataAvailable, inputData controller status and read data
//   isWriting, outputValid, outputAddress, outputData  controller request
//   testActive, compareError, completedSuccess, errorCount,
//   firstErrorAddress, firstErrorData    board status
module sdram_pattern_tester #(
    parameter int unsigned       ADDR_W         = 25,
    parameter int unsigned       DATA_W         = 16,
    parameter int unsigned       START_ADDR     = 0,
    parameter int unsigned       END_ADDR       = 100,
    parameter logic [DATA_W-1:0] CONST_VALUE    = 16'd256,
    parameter logic [DATA_W-1:0] LFSR_SEED      = 16'hACE1,
    parameter logic [DATA_W-1:0] LFSR_TAPS      = 16'hB400,
    parameter bit                STOP_ON_ERROR  = 1'b1,
    parameter int unsigned       TIMEOUT_CYCLES = 1024
) (
    input  logic              inputClock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        patternMode,
    input  logic              isBusy,
    input  logic              inputDataAvailable,
    input  logic [DATA_W-1:0] inputData,
    output logic              isWriting,
    output logic              outputValid,
    output logic [ADDR_W-1:0] outputAddress,
    output logic [DATA_W-1:0] outputData,
    output logic              testActive,
    output logic              compareError,
    output logic              completedSuccess,
    output logic [15:0]       errorCount,
    output logic [ADDR_W-1:0] firstErrorAddress,
    output logic [DATA_W-1:0] firstErrorData
);

    if (END_ADDR < START_ADDR) begin : g_bad_range
        $error("sdram_pattern_tester: END_ADDR must not be below START_ADDR");
    end

    localparam int unsigned       TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] FIRST_A  = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(END_ADDR);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_DONE, S_FAIL
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] lfsr_q, lfsr_d;
    logic              got_q, got_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              is_writing_q, is_writing_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              active_q, active_d;
    logic              err_q, err_d;
    logic              success_q, success_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] first_addr_q, first_addr_d;
    logic [DATA_W-1:0] first_data_q, first_data_d;

    logic [DATA_W-1:0] exp_c;
    logic              strobe_c;
    logic              fail_c;
    logic [DATA_W-1:0] fail_data_c;

    // Galois right-shift LFSR step
    function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : {DATA_W{1'b0}});
    endfunction

    // Expected word for an address under the selected pattern
    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                  input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] s);
        case (m)
            2'd0:    return CONST_VALUE;
            2'd1:    return DATA_W'(a);
            2'd2:    return ~DATA_W'(a);
            default: return s;
        endcase
    endfunction

    // Next-state and next-output logic; outputs follow the state they enter
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        addr_d       = addr_q;
        lfsr_d       = lfsr_q;
        got_d        = got_q;
        tmo_d        = tmo_q;
        is_writing_d = is_writing_q;
        valid_d      = valid_q;
        out_addr_d   = out_addr_q;
        out_data_d   = out_data_q;
        active_d     = active_q;
        err_d        = err_q;
        success_d    = success_q;
        err_cnt_d    = err_cnt_q;
        first_addr_d = first_addr_q;
        first_data_d = first_data_q;
        exp_c        = pattern(mode_q, addr_q, lfsr_q);
        strobe_c     = inputDataAvailable && !got_q;
        fail_c       = 1'b0;
        fail_data_c  = '0;

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    state_d      = S_ARM;
                    mode_d       = patternMode;
                    addr_d       = FIRST_A;
                    lfsr_d       = LFSR_SEED;
                    active_d     = 1'b1;
                    err_d        = 1'b0;
                    success_d    = 1'b0;
                    err_cnt_d    = '0;
                    first_addr_d = '0;
                    first_data_d = '0;
                end
            end
            S_ARM: begin
                if (!isBusy) begin
                    state_d      = S_WR_REQ;
                    valid_d      = 1'b1;
                    is_writing_d = 1'b1;
                    out_addr_d   = addr_q;
                    out_data_d   = exp_c;
                end
            end
            S_WR_REQ: begin
                if (isBusy) begin
                    state_d = S_WR_WAIT;
                    valid_d = 1'b0;
                end
            end
            S_WR_WAIT: begin
                if (!isBusy) begin
                    valid_d = 1'b1;
                    if (addr_q == LAST_A) begin
                        addr_d       = FIRST_A;
                        lfsr_d       = LFSR_SEED;
                        state_d      = S_RD_REQ;
                        is_writing_d = 1'b0;
                        out_addr_d   = FIRST_A;
                    end else begin
                        addr_d       = addr_q + ADDR_W'(1);
                        lfsr_d       = lfsr_step(lfsr_q);
                        state_d      = S_WR_REQ;
                        is_writing_d = 1'b1;
                        out_addr_d   = addr_d;
                        out_data_d   = pattern(mode_q, addr_d, lfsr_d);
                    end
                end
            end
            S_RD_REQ: begin
                if (isBusy) begin
                    state_d = S_RD_WAIT;
                    valid_d = 1'b0;
                    got_d   = 1'b0;
                    tmo_d   = '0;
                end
            end
            S_RD_WAIT: begin
                // First strobe of the read is compared; a timeout counts as a
                // failed word with data 0 and then lets the read complete.
                if (strobe_c) begin
                    got_d = 1'b1;
                    if (inputData != exp_c) begin
                        fail_c      = 1'b1;
                        fail_data_c = inputData;
                    end
                end else if (!got_q) begin
                    if (tmo_q == TMO_LAST) begin
                        fail_c = 1'b1;
                        got_d  = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end

                if (fail_c) begin
                    err_d = 1'b1;
                    if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                    if (!err_q) begin
                        first_addr_d = addr_q;
                        first_data_d = fail_data_c;
                    end
                end

                if (fail_c && STOP_ON_ERROR) begin
                    state_d   = S_FAIL;
                    active_d  = 1'b0;
                    success_d = 1'b0;
                end else if ((got_q || strobe_c) && !isBusy) begin
                    if (addr_q == LAST_A) begin
                        state_d   = S_DONE;
                        active_d  = 1'b0;
                        success_d = !err_d;
                    end else begin
                        addr_d       = addr_q + ADDR_W'(1);
                        lfsr_d       = lfsr_step(lfsr_q);
                        state_d      = S_RD_REQ;
                        valid_d      = 1'b1;
                        is_writing_d = 1'b0;
                        out_addr_d   = addr_d;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge inputClock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            mode_q       <= '0;
            addr_q       <= '0;
            lfsr_q       <= LFSR_SEED;
            got_q        <= 1'b0;
            tmo_q        <= '0;
            is_writing_q <= 1'b0;
            valid_q      <= 1'b0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            active_q     <= 1'b0;
            err_q        <= 1'b0;
            success_q    <= 1'b0;
            err_cnt_q    <= '0;
            first_addr_q <= '0;
            first_data_q <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            addr_q       <= addr_d;
            lfsr_q       <= lfsr_d;
            got_q        <= got_d;
            tmo_q        <= tmo_d;
            is_writing_q <= is_writing_d;
            valid_q      <= valid_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            active_q     <= active_d;
            err_q        <= err_d;
            success_q    <= success_d;
            err_cnt_q    <= err_cnt_d;
            first_addr_q <= first_addr_d;
            first_data_q <= first_data_d;
        end
    end

    assign isWriting         = is_writing_q;
    assign outputValid       = valid_q;
    assign outputAddress     = out_addr_q;
    assign outputData        = out_data_q;
    assign testActive        = active_q;
    assign compareError      = err_q;
    assign completedSuccess  = success_q;
    assign errorCount        = err_cnt_q;
    assign firstErrorAddress = first_addr_q;
    assign firstErrorData    = first_data_q;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed bench for sdram_pattern_tester: two instances (halt-on-error and
// continue-on-error, both with a 16-cycle read timeout) each driven by a small
// controller model with a 2-cycle busy and read data on the busy-low cycle.
module tb_sdram_pattern_tester;

    localparam int AW = 25;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    start = 2'b00;
    logic [1:0]    mode [2] = '{2'd0, 2'd0};
    logic [1:0]    busy, dav, is_wr, valid, active, cerr, succ;
    logic [DW-1:0] rdata [2];
    logic [DW-1:0] odata [2];
    logic [DW-1:0] ferr_data [2];
    logic [AW-1:0] oaddr [2];
    logic [AW-1:0] ferr_addr [2];
    logic [15:0]   ecnt [2];

    int corrupt_a [2] = '{-1, -1};
    int corrupt_b [2] = '{-1, -1};
    int withhold  [2] = '{-1, -1};

    int checks = 0;
    int passes = 0;

    sdram_pattern_tester #(.STOP_ON_ERROR(1'b1), .TIMEOUT_CYCLES(16)) dut0 (
        .inputClock(clk), .reset_n(rst_n), .start(start[0]), .patternMode(mode[0]),
        .isBusy(busy[0]), .inputDataAvailable(dav[0]), .inputData(rdata[0]),
        .isWriting(is_wr[0]), .outputValid(valid[0]), .outputAddress(oaddr[0]),
        .outputData(odata[0]), .testActive(active[0]), .compareError(cerr[0]),
        .completedSuccess(succ[0]), .errorCount(ecnt[0]),
        .firstErrorAddress(ferr_addr[0]), .firstErrorData(ferr_data[0]));

    sdram_pattern_tester #(.STOP_ON_ERROR(1'b0), .TIMEOUT_CYCLES(16)) dut1 (
        .inputClock(clk), .reset_n(rst_n), .start(start[1]), .patternMode(mode[1]),
        .isBusy(busy[1]), .inputDataAvailable(dav[1]), .inputData(rdata[1]),
        .isWriting(is_wr[1]), .outputValid(valid[1]), .outputAddress(oaddr[1]),
        .outputData(odata[1]), .testActive(active[1]), .compareError(cerr[1]),
        .completedSuccess(succ[1]), .errorCount(ecnt[1]),
        .firstErrorAddress(ferr_addr[1]), .firstErrorData(ferr_data[1]));

    // Controller model: accept a request, hold busy 2 cycles, return read
    // data on the cycle busy drops (optionally corrupted or withheld).
    int            cnt [2];
    logic          rd_pend [2];
    logic [AW-1:0] m_addr [2];
    int            wr_count [2];
    int            rd_count [2];
    int            max_rd [2];
    logic [DW-1:0] mem [2][128];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                busy[k]    <= 1'b0;
                dav[k]     <= 1'b0;
                cnt[k]     <= 0;
                rd_pend[k] <= 1'b0;
                rdata[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                dav[k] <= 1'b0;
                if (start[k] && !active[k]) begin
                    wr_count[k] <= 0;
                    rd_count[k] <= 0;
                    max_rd[k]   <= -1;
                end
                if (cnt[k] > 0) begin
                    cnt[k] <= cnt[k] - 1;
                    if (cnt[k] == 1) begin
                        busy[k] <= 1'b0;
                        if (rd_pend[k] && int'(m_addr[k]) != withhold[k]) begin
                            dav[k] <= 1'b1;
                            if (int'(m_addr[k]) == corrupt_a[k] || int'(m_addr[k]) == corrupt_b[k])
                                rdata[k] <= 16'h0000;
                            else
                                rdata[k] <= mem[k][m_addr[k][6:0]];
                        end
                    end
                end else if (valid[k] && !busy[k]) begin
                    busy[k]    <= 1'b1;
                    cnt[k]     <= 2;
                    m_addr[k]  <= oaddr[k];
                    rd_pend[k] <= !is_wr[k];
                    if (is_wr[k]) begin
                        mem[k][oaddr[k][6:0]] <= odata[k];
                        wr_count[k] <= wr_count[k] + 1;
                    end else begin
                        rd_count[k] <= rd_count[k] + 1;
                        if (int'(oaddr[k]) > max_rd[k]) max_rd[k] <= int'(oaddr[k]);
                    end
                end
            end
        end
    end

    // Timeout latency monitor on instance 1: read request to address 12
    // (valid falling) versus the first errorCount update.
    int   cyc = 0;
    logic prev_v1 = 1'b0;
    int   t_rd12 = -1;
    int   t_err = -1;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        prev_v1 <= valid[1];
        if (prev_v1 && !valid[1] && !is_wr[1] && int'(oaddr[1]) == 12 && t_rd12 < 0)
            t_rd12 <= cyc;
        if (ecnt[1] != 16'd0 && t_err < 0)
            t_err <= cyc;
        if (start[1]) begin
            t_rd12 <= -1;
            t_err  <= -1;
        end
    end

    function automatic logic [15:0] tb_lfsr_next(input logic [15:0] s);
        logic [15:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    task automatic pulse_start(input int k, input logic [1:0] m);
        @(negedge clk);
        mode[k]  = m;
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (!active[k]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (valid !== 2'b00) $display("FAIL reset_valid: got %b want 00", valid); else passes++;
        checks++; if (active !== 2'b00) $display("FAIL reset_active: got %b want 00", active); else passes++;
        checks++; if ({cerr, succ} !== 4'b0000) $display("FAIL reset_status: got %b want 0000", {cerr, succ}); else passes++;
        checks++; if (ecnt[0] !== 16'd0 || oaddr[0] !== '0 || odata[0] !== '0 || ferr_addr[0] !== '0)
            $display("FAIL reset_regs: cnt %0h addr %0h data %0h ferr %0h want all 0", ecnt[0], oaddr[0], odata[0], ferr_addr[0]);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mode0();
        bit ok;
        int bad;
        pulse_start(0, 2'd0);
        checks++; if (active[0] !== 1'b1) $display("FAIL m0_active: got %b want 1", active[0]); else passes++;
        wait_done(0, ok);
        checks++; if (!ok) $display("FAIL m0_timeout: testActive still %b want 0", active[0]); else passes++;
        checks++; if (succ[0] !== 1'b1 || cerr[0] !== 1'b0 || ecnt[0] !== 16'd0)
            $display("FAIL m0_status: succ %b cerr %b cnt %0d want 1 0 0", succ[0], cerr[0], ecnt[0]);
        else passes++;
        checks++; if (wr_count[0] != 101 || rd_count[0] != 101)
            $display("FAIL m0_counts: wr %0d rd %0d want 101 101", wr_count[0], rd_count[0]);
        else passes++;
        bad = 0;
        for (int a = 0; a <= 100; a++) if (mem[0][a] !== 16'd256) bad++;
        checks++; if (bad != 0) $display("FAIL m0_data: %0d words differ from 0100", bad); else passes++;
    endtask

    task automatic test_lfsr();
        bit ok;
        int bad;
        logic [15:0] s;
        pulse_start(0, 2'd3);
        wait_done(0, ok);
        checks++; if (!ok) $display("FAIL lfsr_timeout: testActive still %b want 0", active[0]); else passes++;
        checks++; if (mem[0][0] !== 16'hACE1 || mem[0][1] !== 16'hE270)
            $display("FAIL lfsr_first: got %h %h want ace1 e270", mem[0][0], mem[0][1]);
        else passes++;
        bad = 0;
        s = 16'hACE1;
        for (int a = 0; a <= 100; a++) begin
            if (mem[0][a] !== s) bad++;
            s = tb_lfsr_next(s);
        end
        checks++; if (bad != 0) $display("FAIL lfsr_seq: %0d words differ from sequence", bad); else passes++;
        checks++; if (succ[0] !== 1'b1 || ecnt[0] !== 16'd0)
            $display("FAIL lfsr_status: succ %b cnt %0d want 1 0", succ[0], ecnt[0]);
        else passes++;
    endtask

    task automatic test_stop_on_error();
        bit ok;
        corrupt_a[0] = 37;
        pulse_start(0, 2'd1);
        wait_done(0, ok);
        checks++; if (!ok) $display("FAIL stop_timeout: testActive still %b want 0", active[0]); else passes++;
        checks++; if (cerr[0] !== 1'b1 || succ[0] !== 1'b0 || ecnt[0] !== 16'd1)
            $display("FAIL stop_status: cerr %b succ %b cnt %0d want 1 0 1", cerr[0], succ[0], ecnt[0]);
        else passes++;
        checks++; if (ferr_addr[0] !== 25'd37 || ferr_data[0] !== 16'h0000)
            $display("FAIL stop_first: addr %0d data %h want 37 0000", ferr_addr[0], ferr_data[0]);
        else passes++;
        checks++; if (max_rd[0] != 37) $display("FAIL stop_last_read: got %0d want 37", max_rd[0]); else passes++;
        corrupt_a[0] = -1;
    endtask

    task automatic test_continue();
        bit ok;
        corrupt_a[1] = 5;
        corrupt_b[1] = 9;
        pulse_start(1, 2'd1);
        wait_done(1, ok);
        checks++; if (!ok) $display("FAIL cont_timeout: testActive still %b want 0", active[1]); else passes++;
        checks++; if (cerr[1] !== 1'b1 || succ[1] !== 1'b0 || ecnt[1] !== 16'd2)
            $display("FAIL cont_status: cerr %b succ %b cnt %0d want 1 0 2", cerr[1], succ[1], ecnt[1]);
        else passes++;
        checks++; if (ferr_addr[1] !== 25'd5 || ferr_data[1] !== 16'h0000)
            $display("FAIL cont_first: addr %0d data %h want 5 0000", ferr_addr[1], ferr_data[1]);
        else passes++;
        checks++; if (rd_count[1] != 101) $display("FAIL cont_reads: got %0d want 101", rd_count[1]); else passes++;
        corrupt_a[1] = -1;
        corrupt_b[1] = -1;
    endtask

    task automatic test_timeout();
        bit ok;
        withhold[1] = 12;
        pulse_start(1, 2'd0);
        wait_done(1, ok);
        checks++; if (!ok) $display("FAIL tmo_timeout: testActive still %b want 0", active[1]); else passes++;
        checks++; if (ecnt[1] !== 16'd1 || cerr[1] !== 1'b1 || succ[1] !== 1'b0)
            $display("FAIL tmo_status: cnt %0d cerr %b succ %b want 1 1 0", ecnt[1], cerr[1], succ[1]);
        else passes++;
        checks++; if (ferr_addr[1] !== 25'd12 || ferr_data[1] !== 16'h0000)
            $display("FAIL tmo_first: addr %0d data %h want 12 0000", ferr_addr[1], ferr_data[1]);
        else passes++;
        checks++; if (t_rd12 < 0 || t_err - t_rd12 != 16)
            $display("FAIL tmo_latency: got %0d cycles (rd %0d err %0d) want 16", t_err - t_rd12, t_rd12, t_err);
        else passes++;
        checks++; if (rd_count[1] != 101) $display("FAIL tmo_reads: got %0d want 101", rd_count[1]); else passes++;
        withhold[1] = -1;
    endtask

    task automatic test_async_reset();
        bit seen;
        pulse_start(0, 2'd2);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (valid[0] && is_wr[0] && oaddr[0] == 25'd3) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) $display("FAIL arst_reach: no write request to address 3 seen"); else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (valid[0] !== 1'b0 || active[0] !== 1'b0 || is_wr[0] !== 1'b0)
            $display("FAIL arst_outputs: valid %b active %b wr %b want 0 0 0", valid[0], active[0], is_wr[0]);
        else passes++;
        checks++; if (oaddr[0] !== '0 || odata[0] !== '0)
            $display("FAIL arst_bus: addr %0h data %h want 0 0", oaddr[0], odata[0]);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int bad;
        pulse_start(0, 2'd2);
        repeat (200) @(negedge clk);
        pulse_start(0, 2'd0);
        wait_done(0, ok);
        checks++; if (!ok) $display("FAIL b2b_timeout: testActive still %b want 0", active[0]); else passes++;
        checks++; if (succ[0] !== 1'b1 || ecnt[0] !== 16'd0 || wr_count[0] != 101)
            $display("FAIL b2b_status: succ %b cnt %0d wr %0d want 1 0 101", succ[0], ecnt[0], wr_count[0]);
        else passes++;
        bad = 0;
        for (int a = 0; a <= 100; a++) begin
            logic [15:0] e;
            e = ~16'(a);
            if (mem[0][a] !== e) bad++;
        end
        checks++; if (bad != 0) $display("FAIL b2b_data: %0d words differ from ~addr", bad); else passes++;
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_lfsr();
        test_stop_on_error();
        test_continue();
        test_timeout();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
